// File: rtl/an_pkg.sv
// Shared constants, FSM state type and LFSR step for the AN-code encoder
// with single-bit error injection.
package an_pkg;

  localparam int A_W   = 5;
  localparam logic [A_W-1:0] A = 5'd29;
  localparam int N_W   = 9;
  localparam int C_W   = 14;
  localparam int N_MAX = 123;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, expressed as the bits tapped in a right-shifting register
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 16'h002D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    INJ  = 2'd2,
    OUT  = 2'd3
  } an_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAP_MASK), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/an_lfsr16.sv
// 16-bit Fibonacci LFSR choosing the error position; steps once per strobe.
module an_lfsr16
  import an_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  output logic [LFSR_W-1:0] lfsr
);

  // An all-zero register would lock up, so a zero seed becomes 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED_EFF;
    end else if (adv) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/an_encoder_inj.sv
// Serial shift-add AN-code encoder with optional single-bit error injection.
// Injection hardware is present only when ANENC_ERR_INJ_EN is defined.
module an_encoder_inj
  import an_pkg::*;
#(
  parameter int               A_W   = an_pkg::A_W,
  parameter logic [A_W-1:0]   A     = an_pkg::A,
  parameter int               N_W   = an_pkg::N_W,
  parameter int               C_W   = an_pkg::C_W,
  parameter int               N_MAX = an_pkg::N_MAX,
  parameter logic [15:0]      SEED  = an_pkg::LFSR_SEED
) (
  input  logic           clk,
  input  logic           rst_n,
  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // A producer holds valid and data stable until that edge; ready never
  // depends combinationally on valid.
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] in_n,
  input  logic           inj_en,
  input  logic           inj_force_en,
  input  logic [3:0]     inj_force_bit,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [C_W-1:0] out_ane,
  output logic [C_W-1:0] out_an,
  output logic           out_err_flag,
  output logic [3:0]     out_err_bit,
  output logic           out_ovf,
  output an_state_e      dbg_state
);

  localparam int CNT_W = (A_W > 1) ? $clog2(A_W) : 1;

  an_state_e        state;
  logic [N_W-1:0]   n_q;
  logic [C_W-1:0]   acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             accept;
  logic             inj_hit;
  logic [3:0]       inj_pos;

  assign in_ready  = (state == IDLE);
  assign accept    = in_ready && in_valid;
  assign dbg_state = state;

`ifdef ANENC_ERR_INJ_EN
  logic        inj_en_q;
  logic        inj_force_en_q;
  logic [3:0]  inj_force_bit_q;
  logic [15:0] lfsr;

  // Steps on every accepted word so INJ sees the freshly advanced value.
  an_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (accept),
    .lfsr  (lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_en_q        <= 1'b0;
      inj_force_en_q  <= 1'b0;
      inj_force_bit_q <= '0;
    end else if (accept) begin
      inj_en_q        <= inj_en;
      inj_force_en_q  <= inj_force_en;
      inj_force_bit_q <= inj_force_bit;
    end
  end

  always_comb begin
    inj_pos = inj_force_en_q ? inj_force_bit_q : lfsr[3:0];
    inj_hit = inj_en_q && (int'(inj_pos) < C_W);
  end
`else
  assign inj_pos = '0;
  assign inj_hit = 1'b0;

  logic unused_inj;
  assign unused_inj = ^{inj_en, inj_force_en, inj_force_bit, SEED};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      n_q          <= '0;
      acc          <= '0;
      cnt          <= '0;
      ovf_q        <= 1'b0;
      out_valid    <= 1'b0;
      out_ane      <= '0;
      out_an       <= '0;
      out_err_flag <= 1'b0;
      out_err_bit  <= '0;
      out_ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            n_q   <= in_n;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= (in_n > N_W'(N_MAX));
            state <= MUL;
          end
        end
        MUL: begin
          if (A[cnt]) begin
            acc <= acc + (C_W'(n_q) << cnt);
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(A_W - 1)) begin
            state <= INJ;
          end
        end
        INJ: begin
          out_an       <= acc;
          out_ane      <= inj_hit ? (acc ^ (C_W'(1) << inj_pos)) : acc;
          out_err_flag <= inj_hit;
          out_err_bit  <= inj_hit ? inj_pos : 4'd0;
          out_ovf      <= ovf_q;
          out_valid    <= 1'b1;
          state        <= OUT;
        end
        OUT: begin
          // Outputs stay frozen until the consumer takes the word.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/an_encoder_inj.md
# an_encoder_inj

Sequential AN-code encoder with single-bit error injection, one stage upstream of the AN decoder in the BER test chain. It accepts a data word N over a valid/ready handshake and computes AN = A·N with a serial shift-add multiplier. It can flip one codeword bit, chosen by an LFSR or forced by the bench, and presents the corrupted word ANe plus the injected position to the decoder and the BER scoreboard.

## Interface
- A, 29: code constant.
- A_W, 5: bit width of A.
- N_W, 9: data width.
- C_W, 14: codeword width; must be ≥ N_W+A_W.
- N_MAX, 123: largest in-range data value.
- SEED, 16'hACE1: LFSR reset value. 0 is replaced by 16'h0001.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  data word offered.
- in_ready  out  1  encoder can accept.
- in_n  in  N_W  data word N.
- inj_en  in  1  enable error injection for the next accepted word.
- inj_force_en  in  1  use inj_force_bit instead of the LFSR position.
- inj_force_bit  in  4  forced error position.
- out_valid  out  1  codeword available.
- out_ready  in  1  consumer takes codeword.
- out_ane  out  C_W  codeword after injection (decoder input).
- out_an  out  C_W  clean codeword A·N.
- out_err_flag  out  1  a bit was flipped.
- out_err_bit  out  4  flipped position; 0 when out_err_flag=0.
- out_ovf  out  1  accepted N > N_MAX.

## Operation
- FSM states: IDLE, MUL, INJ, OUT.
- in_ready = (state==IDLE).
- IDLE:
  - On in_valid: latch in_n, inj_en, inj_force_en and inj_force_bit.
  - Clear acc and cnt.
  - Set ovf = (in_n > N_MAX).
  - Go to MUL.
- MUL, A_W cycles:
  - If A[cnt], acc += N << cnt; acc is C_W bits wide.
  - After cnt == A_W-1, go to INJ.
- INJ:
  - pos = forced ? inj_force_bit : lfsr[3:0].
  - Inject only if inj_en && pos < C_W: out_ane = acc ^ (1<<pos), out_err_flag=1, out_err_bit=pos.
  - Otherwise out_ane = acc, flag 0, bit 0.
  - out_an = acc.
  - Go to OUT.
- OUT:
  - out_valid=1; all out_* held stable.
  - On out_ready, go to IDLE and clear out_valid.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances exactly once per accepted input word (the IDLE handshake edge), whatever inj_en is.
  - INJ therefore uses the advanced value.
- Overflow: N > N_MAX is still encoded; out_ovf=1 marks it for the scoreboard. Product width is sufficient for N up to 2^N_W-1.
- Reset, asynchronous, any state:
  - state=IDLE, out_valid=0.
  - out_ane, out_an, out_err_bit = 0; out_err_flag, out_ovf = 0.
  - lfsr=SEED.
  - In-flight word discarded; in_ready=1 once reset is released.

## Timing
- Acceptance edge E0.
- MUL on edges E1–E5.
- INJ applied at E6; out_valid is high from E6.
- Earliest output handshake at E7, after which in_ready is high again.
- Next acceptance at E8: minimum period 8 cycles.
- No combinational path from in_* to out_*; in_ready depends only on state.
- Backpressure: while out_valid && !out_ready, outputs are frozen and in_ready=0 indefinitely.
- inj_* inputs are sampled only at the acceptance edge.

## Configuration
- ANENC_ERR_INJ_EN defined:
  - LFSR, force path and XOR stage present as described.
- Not defined:
  - No LFSR.
  - out_ane == out_an; out_err_flag=0 and out_err_bit=0 always.
  - inj_* inputs ignored.
  - INJ state still occupies one cycle, so latency is unchanged.

## Structure
- Shared package an_pkg:
  - A, A_W, N_W, C_W, N_MAX defaults.
  - LFSR taps and width.
  - FSM state enum.
- One sub-module, an_lfsr16: seed, advance strobe, 16-bit state.
- FSM and shift-add datapath stay in the top module.

## Test plan
- Clean encode: N=123, inj_en=0 → out_an=out_ane=3567, flag 0, out_ovf=0, out_valid at E6.
- Forced errors on N=123, inj_en=1, inj_force_en=1:
  - bit 4 → out_ane=3583, out_err_bit=4.
  - bit 13 → out_ane=11759.
  - bit 0 → out_ane=3566.
- Invalid forced position: inj_force_bit=14 or 15 with inj_en=1 → out_ane=3567, flag 0.
- Range edges:
  - N=0 → 0.
  - N=511 → out_an=14819, out_ovf=1.
  - N=124 → out_an=3596, out_ovf=1.
- Backpressure: out_ready low 10 cycles after out_valid → outputs stable, in_ready=0; back-to-back words with out_ready=1 → 8-cycle period.
- Reset and LFSR:
  - rst_n low during MUL → all outputs 0 immediately, next word encodes correctly.
  - LFSR sequence after reset matches the reference model from SEED.
  - Build without ANENC_ERR_INJ_EN → flag never set.
